// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA division arbiter and its sequential divider.
package rsa_pkg;

  localparam int DIV_WIDTH = 16;

  // Quotient reported for a zero divisor; truncated to the operand width at use.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; the first bit is resolved on the start edge.
module seq_divider
  import rsa_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    shifted = {src_rem, src_quo[WIDTH-1]};
    diff    = shifted - {1'b0, src_dvs};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start || (run_q && cnt_q != '0)) begin
      // A borrow out of the trial subtraction means the divisor did not fit: restore.
      if (diff[WIDTH]) begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {src_quo[WIDTH-2:0], 1'b0};
      end else begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {src_quo[WIDTH-2:0], 1'b1};
      end
      dvs_d = src_dvs;
      cnt_d = start ? CW'(WIDTH - 1) : cnt_q - CW'(1);
      run_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign ready     = run_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider among NREQ requesters.
// DIV_ARB_LOCK_EN adds a lock input that lets a requester keep the divider back-to-back.
module div_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
`ifdef DIV_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  input  logic [NREQ*WIDTH-1:0] dividend,
  input  logic [NREQ*WIDTH-1:0] divisor,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      quotient,
  output logic [WIDTH-1:0]      remainder,
  output logic                  div_zero,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, zdvd_q, zdvd_d;
  logic             zero_q, zero_d, dz_q, dz_d, busy_q, busy_d;
  logic [WIDTH-1:0] sel_dvd, sel_dvs, div_quo, div_rem;
  logic             div_start, div_ready, relock, found;
  int               cand;

  // last_q doubles as the index of the requester currently being served.
  assign sel_dvd = dividend[int'(last_q)*WIDTH +: WIDTH];
  assign sel_dvs = divisor[int'(last_q)*WIDTH +: WIDTH];

`ifdef DIV_ARB_LOCK_EN
  assign relock = lock[last_q] & req[last_q];
`else
  assign relock = 1'b0;
`endif

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (sel_dvd),
    .divisor   (sel_dvs),
    .quotient  (div_quo),
    .remainder (div_rem),
    .ready     (div_ready)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    dz_d      = 1'b0;
    quot_d    = quot_q;
    rem_d     = rem_q;
    zdvd_d    = zdvd_q;
    zero_d    = zero_q;
    div_start = 1'b0;
    found     = 1'b0;
    cand      = 0;
    case (state_q)
      ST_IDLE: begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && req[(int'(last_q) + k) % NREQ]) begin
            found = 1'b1;
            cand  = (int'(last_q) + k) % NREQ;
          end
        end
        if (found) begin
          state_d     = ST_LOAD;
          last_d      = cand[IW-1:0];
          gnt_d       = '0;
          gnt_d[cand] = 1'b1;
        end
      end
      ST_LOAD: begin
        zero_d    = (sel_dvs == '0);
        zdvd_d    = sel_dvd;
        div_start = (sel_dvs != '0);
        state_d   = (sel_dvs == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (div_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d = gnt_q;
        dz_d   = zero_q;
        quot_d = zero_q ? DIV_ZERO_QUOT[WIDTH-1:0] : div_quo;
        rem_d  = zero_q ? zdvd_q : div_rem;
        if (relock) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      zdvd_q  <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      zdvd_q  <= zdvd_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign busy      = busy_q;

endmodule
